pipeline_controller: RTL

Hazard and run-control sequencer for the 5-stage RV32I pipeline (IF/DE/EX/ME/WB). It produces PC and IF/DE enables and bubble/flush strobes for IF/DE and DE/EX, covering load-use stalls and taken-branch flushes. It also runs a halt/drain/single-step state machine for debug and keeps wrap-around performance counters. It sits beside the forwarding unit; the existing PC and pipeline registers gain enable/flush inputs driven from here.

---
 rtl/pipeline_controller_pkg.sv | 18 +
 rtl/pipeline_controller_if.sv | 37 +++
 rtl/pipeline_controller_hazard_detect.sv | 24 ++
 rtl/pipeline_controller.sv | 135 +++++++++++++
 4 files changed

// File: rtl/pipeline_controller_pkg.sv
// Shared types and constants for the pipeline run-control sequencer.
// Holds the controller state encoding and the pipeline encodings it depends on.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } ctrl_state_e;

    // Writeback source selecting data memory, i.e. a load in EX.
    localparam logic [1:0]  RU_SRC_MEM           = 2'b01;
    // addi x0,x0,0 loaded by the IF/DE register when it is flushed.
    localparam logic [31:0] NOP_INSTR            = 32'h00000013;
    localparam int          DEFAULT_DRAIN_CYCLES = 3;

endpackage

// File: rtl/pipeline_controller_if.sv
// Bundle between the pipeline datapath and the run-control sequencer.
// master: datapath/debug side (drives hazard info, halt/step); slave: controller.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1_de;
    logic [4:0]       rs2_de;
    logic [4:0]       rd_ex;
    logic             ru_write_ex;
    logic [1:0]       ru_data_src_ex;
    logic             next_pc_src;
    logic             halt_req;
    logic             step_req;
    logic             pc_en;
    logic             if_de_en;
    logic             if_de_flush;
    logic             de_ex_flush;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output rs1_de, rs2_de, rd_ex, ru_write_ex, ru_data_src_ex,
        output next_pc_src, halt_req, step_req,
        input  pc_en, if_de_en, if_de_flush, de_ex_flush, halted,
        input  cycle_count, stall_count, flush_count
    );

    modport slave (
        input  rs1_de, rs2_de, rd_ex, ru_write_ex, ru_data_src_ex,
        input  next_pc_src, halt_req, step_req,
        output pc_en, if_de_en, if_de_flush, de_ex_flush, halted,
        output cycle_count, stall_count, flush_count
    );

endinterface

// File: rtl/pipeline_controller_hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources in DE.
// In: rs1_de, rs2_de, rd_ex, ru_write_ex, ru_data_src_ex. Out: load_use.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] rs1_de,
    input  logic [4:0] rs2_de,
    input  logic [4:0] rd_ex,
    input  logic       ru_write_ex,
    input  logic [1:0] ru_data_src_ex,
    output logic       load_use
);

    logic is_load;
    logic rd_live;
    logic rd_hit;

    assign is_load  = ru_write_ex && (ru_data_src_ex == RU_SRC_MEM);
    // x0 is never a real dependency.
    assign rd_live  = (rd_ex != 5'd0);
    assign rd_hit   = (rd_ex == rs1_de) || (rd_ex == rs2_de);
    assign load_use = is_load && rd_live && rd_hit;

endmodule

// File: rtl/pipeline_controller.sv
// Hazard and run-control sequencer: PC/IF-DE enables, flush strobes, debug FSM.
// Ports: clk, reset (async, active-high), bus (pipeline_ctrl_if.slave).
module pipeline_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    pipeline_ctrl_if.slave  bus
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    ctrl_state_e      state_q;
    ctrl_state_e      state_d;
    logic [DW-1:0]    drain_q;
    logic [DW-1:0]    drain_d;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    logic load_use;
    logic pc_en;
    logic if_de_en;
    logic if_de_flush;
    logic de_ex_flush;
    logic stall_inc;
    logic flush_inc;

    hazard_detect u_hazard (
        .rs1_de         (bus.rs1_de),
        .rs2_de         (bus.rs2_de),
        .rd_ex          (bus.rd_ex),
        .ru_write_ex    (bus.ru_write_ex),
        .ru_data_src_ex (bus.ru_data_src_ex),
        .load_use       (load_use)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        pc_en       = 1'b1;
        if_de_en    = 1'b1;
        if_de_flush = 1'b0;
        de_ex_flush = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        unique case (state_q)
            RUN, STEP: begin
                // A taken branch squashes DE anyway, so it wins over a stall.
                if (bus.next_pc_src) begin
                    if_de_flush = 1'b1;
                    de_ex_flush = 1'b1;
                    flush_inc   = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_de_en    = 1'b0;
                    de_ex_flush = 1'b1;
                    stall_inc   = 1'b1;
                end
                if ((state_q == STEP) || bus.halt_req) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                // Keep the redirect target of a branch retiring from EX.
                pc_en       = bus.next_pc_src;
                if_de_flush = 1'b1;
                de_ex_flush = 1'b1;
                flush_inc   = bus.next_pc_src;
                if (drain_q == '0) begin
                    state_d = HALTED;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            HALTED: begin
                pc_en       = 1'b0;
                if_de_en    = 1'b0;
                if_de_flush = 1'b1;
                de_ex_flush = 1'b1;
                if (!bus.halt_req) begin
                    state_d = RUN;
                end else if (bus.step_req) begin
                    state_d = STEP;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (state_q != HALTED) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end
            if (stall_inc) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_inc) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.if_de_en    = if_de_en;
    assign bus.if_de_flush = if_de_flush;
    assign bus.de_ex_flush = de_ex_flush;
    assign bus.halted      = (state_q == HALTED);
    assign bus.cycle_count = cycle_q;
    assign bus.stall_count = stall_q;
    assign bus.flush_count = flush_q;

endmodule
